// File: rtl/conv_7x7_pipe.sv
// 7x7 signed-coefficient convolution over a streamed window: multiply, row sums,
// total, then round/shift/clamp. Four register stages and no back-pressure.
module conv_7x7_pipe #(
  parameter int IMG_Width  = 8,
  parameter int IMG_Height = 8,
  parameter int Datawidth  = 8,
  parameter int Coef_Width = 8,
  parameter int Shift      = 6
) (
  input  logic                      CLK,
  input  logic                      CLR,
  input  logic [49*Datawidth-1:0]   Win,
  input  logic                      Valid_IN,
  input  logic                      Coef_WE,
  input  logic [5:0]                Coef_Addr,
  input  logic [Coef_Width-1:0]     Coef_Data,
  output logic [Datawidth-1:0]      Out,
  output logic                      Valid_OUT,
  output logic                      Frame_Done
);

  localparam int PW    = Datawidth + 1 + Coef_Width;
  localparam int RW    = PW + 3;
  localparam int TW    = PW + 6;
  localparam int XW    = TW + 1;
  localparam int COL_W = $clog2(IMG_Width);
  localparam int ROW_W = $clog2(IMG_Height);
  localparam logic signed [XW-1:0] RND     = XW'(2 ** (Shift - 1));
  localparam logic signed [XW-1:0] MAX_OUT = XW'(2 ** Datawidth - 1);

  logic signed [Coef_Width-1:0] coef [49];
  logic [COL_W-1:0]             col;
  logic [ROW_W-1:0]             row;
  logic                         col_last, row_last, qual;
  logic signed [PW-1:0]         prod [49];
  logic signed [RW-1:0]         row_sum [7];
  logic signed [RW-1:0]         row_sum_d [7];
  logic signed [TW-1:0]         total, total_d;
  logic signed [XW-1:0]         rounded, shifted;
  logic [Datawidth-1:0]         clamped;
  logic [3:0]                   vld_sr, last_sr;

  assign col_last = (col == COL_W'(IMG_Width - 1));
  assign row_last = (row == ROW_W'(IMG_Height - 1));
  assign qual     = Valid_IN && (col >= COL_W'(6)) && (row >= ROW_W'(6));

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      col <= '0;
      row <= '0;
    end else if (Valid_IN) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Stage 1 reads the old coefficient on the same edge a write lands.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < 49; i++) coef[i] <= '0;
      coef[24] <= Coef_Width'(2 ** Shift);
    end else if (Coef_WE && (Coef_Addr < 6'd49)) begin
      coef[Coef_Addr] <= Coef_Data;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < 49; i++) prod[i] <= '0;
    end else begin
      for (int i = 0; i < 49; i++)
        prod[i] <= PW'($signed({1'b0, Win[i*Datawidth +: Datawidth]})) * PW'(coef[i]);
    end
  end

  always_comb begin
    for (int r = 0; r < 7; r++) row_sum_d[r] = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        row_sum_d[r] = row_sum_d[r] + RW'(prod[r*7+c]);
  end

  always_comb begin
    total_d = '0;
    for (int r = 0; r < 7; r++) total_d = total_d + TW'(row_sum[r]);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int r = 0; r < 7; r++) row_sum[r] <= '0;
      total <= '0;
    end else begin
      for (int r = 0; r < 7; r++) row_sum[r] <= row_sum_d[r];
      total <= total_d;
    end
  end

  always_comb begin
    rounded = XW'(total) + RND;
    shifted = rounded >>> Shift;
    clamped = '0;
    if (shifted[XW-1])
      clamped = '0;
    else if (shifted > MAX_OUT)
      clamped = '1;
    else
      clamped = shifted[Datawidth-1:0];
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      vld_sr  <= '0;
      last_sr <= '0;
      Out     <= '0;
    end else begin
      vld_sr  <= {vld_sr[2:0], qual};
      last_sr <= {last_sr[2:0], qual & col_last & row_last};
      if (vld_sr[2]) Out <= clamped;
    end
  end

  assign Valid_OUT  = vld_sr[3];
  assign Frame_Done = last_sr[3];

endmodule

// File: tb/tb_conv_7x7_pipe.sv
// Bench for conv_7x7_pipe: fixed-value vector table plus randomized frames,
// all checked cycle by cycle against an arithmetic reference model.
module tb_conv_7x7_pipe;
  localparam int W = 8, H = 8, DW = 8, CW = 8, SH = 6;

  logic              clk = 1'b0;
  logic              CLR = 1'b1;
  logic [49*DW-1:0]  Win = '0;
  logic              Valid_IN = 1'b0;
  logic              Coef_WE = 1'b0;
  logic [5:0]        Coef_Addr = '0;
  logic [CW-1:0]     Coef_Data = '0;
  logic [DW-1:0]     Out;
  logic              Valid_OUT;
  logic              Frame_Done;

  conv_7x7_pipe #(.IMG_Width(W), .IMG_Height(H), .Datawidth(DW), .Coef_Width(CW), .Shift(SH)) dut (
    .CLK(clk), .CLR(CLR), .Win(Win), .Valid_IN(Valid_IN), .Coef_WE(Coef_WE),
    .Coef_Addr(Coef_Addr), .Coef_Data(Coef_Data), .Out(Out), .Valid_OUT(Valid_OUT),
    .Frame_Done(Frame_Done)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int val; bit last; } exp_t;
  typedef struct { int mode; int pix; int exp_out; } vec_t;

  int   n_vec = 0, n_err = 0;
  int   cyc = 0;
  int   m_coef[49];
  int   m_idx = 0;
  int   win_px[49];
  exp_t q[$];
  int   exp_out = 0;
  int   vo_cnt = 0, fd_cnt = 0, last_seen = 0;
  vec_t tbl[5];

  function automatic int ref_pixel(input int px[49], input int cf[49]);
    int s, num, r;
    s = 0;
    for (int i = 0; i < 49; i++) s += px[i] * cf[i];
    num = s + (1 << (SH - 1));
    if (num >= 0) r = num / (1 << SH);
    else          r = -(((-num) + (1 << SH) - 1) / (1 << SH));
    if (r < 0) r = 0;
    if (r > (1 << DW) - 1) r = (1 << DW) - 1;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic drive_win();
    for (int i = 0; i < 49; i++) Win[i*DW +: DW] = DW'(win_px[i]);
  endtask

  task automatic model_identity();
    for (int i = 0; i < 49; i++) m_coef[i] = 0;
    m_coef[24] = 1 << SH;
  endtask

  // Advance one clock: update the model from what the DUT sampled, then check.
  task automatic tick();
    bit exp_v, exp_fd;
    int col, row;
    @(posedge clk);
    cyc++;
    if (CLR) begin
      if (Valid_IN) begin
        col = m_idx % W;
        row = m_idx / W;
        if (col >= 6 && row >= 6)
          q.push_back('{due: cyc + 3, val: ref_pixel(win_px, m_coef), last: (m_idx == W*H-1)});
        m_idx = (m_idx + 1) % (W*H);
      end
      if (Coef_WE && Coef_Addr < 49) m_coef[Coef_Addr] = int'($signed(Coef_Data));
    end
    #1;
    exp_v = 1'b0;
    exp_fd = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_v = 1'b1;
      exp_out = q[0].val;
      exp_fd = q[0].last;
      void'(q.pop_front());
    end
    check("valid_out", int'(Valid_OUT), int'(exp_v));
    check("out", int'(Out), exp_out);
    check("frame_done", int'(Frame_Done), int'(exp_fd));
    if (Valid_OUT) begin vo_cnt++; last_seen = int'(Out); end
    if (Frame_Done) fd_cnt++;
  endtask

  // Drop CLR part-way through the cycle; outputs must clear without a clock.
  task automatic apply_reset();
    #2;
    CLR = 1'b0;
    Valid_IN = 1'b0;
    Coef_WE = 1'b0;
    #1;
    check("rst_out", int'(Out), 0);
    check("rst_valid", int'(Valid_OUT), 0);
    check("rst_fd", int'(Frame_Done), 0);
    q.delete();
    m_idx = 0;
    model_identity();
    exp_out = 0;
    tick();
    tick();
    CLR = 1'b1;
  endtask

  task automatic wr_coef(input int addr, input int data);
    Coef_WE = 1'b1;
    Coef_Addr = 6'(addr);
    Coef_Data = CW'(data);
    Valid_IN = 1'b0;
    tick();
    Coef_WE = 1'b0;
  endtask

  task automatic set_coefs(input int mode);
    int d;
    for (int i = 0; i < 49; i++) begin
      if (mode == 1)      d = 1;
      else if (i != 24)   d = 0;
      else if (mode == 2) d = -64;
      else                d = 127;
      wr_coef(i, d);
    end
  endtask

  // pat: 0 uniform pix, 1 centre 0x5A others random, 2 deterministic per beat, 3 random
  task automatic fill_win(input int pat, input int pix, input int b);
    for (int i = 0; i < 49; i++) begin
      case (pat)
        0:       win_px[i] = pix;
        1:       win_px[i] = (i == 24) ? 8'h5A : int'($urandom_range(0, 255));
        2:       win_px[i] = (b * 7 + i * 13) % 256;
        default: win_px[i] = int'($urandom_range(0, 255));
      endcase
    end
    drive_win();
  endtask

  task automatic run_beats(input int nbeats, input int gap, input int pat, input int pix, input bit cwr);
    for (int b = 0; b < nbeats; b++) begin
      fill_win(pat, pix, b);
      Valid_IN = 1'b1;
      if (cwr && $urandom_range(0, 3) == 0) begin
        Coef_WE = 1'b1;
        Coef_Addr = 6'($urandom_range(0, 63));
        Coef_Data = CW'($urandom_range(0, 9) - 3);
      end
      tick();
      Valid_IN = 1'b0;
      Coef_WE = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic drain();
    Valid_IN = 1'b0;
    Coef_WE = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("queue_empty", q.size(), 0);
  endtask

  task automatic full_frame(input int gap, input int pat, input int pix, input bit cwr);
    int v0, f0;
    v0 = vo_cnt;
    f0 = fd_cnt;
    run_beats(W*H, gap, pat, pix, cwr);
    drain();
    check("frame_outputs", vo_cnt - v0, (W-6)*(H-6));
    check("frame_done_count", fd_cnt - f0, 1);
  endtask

  initial begin
    tbl[0] = '{mode: 0, pix: 0,   exp_out: 8'h5A};
    tbl[1] = '{mode: 1, pix: 255, exp_out: 195};
    tbl[2] = '{mode: 1, pix: 10,  exp_out: 8};
    tbl[3] = '{mode: 2, pix: 100, exp_out: 0};
    tbl[4] = '{mode: 3, pix: 255, exp_out: 255};

    model_identity();
    apply_reset();

    for (int t = 0; t < 5; t++) begin
      if (tbl[t].mode == 0) apply_reset();
      else                  set_coefs(tbl[t].mode);
      full_frame(0, (tbl[t].mode == 0) ? 1 : 0, tbl[t].pix, 1'b0);
      check($sformatf("table_%0d", t), last_seen, tbl[t].exp_out);
    end

    // Two gapless frames back to back, then the same content gapped 1-on/2-off.
    set_coefs(1);
    wr_coef(24, -20);
    wr_coef(3, 5);
    full_frame(0, 2, 0, 1'b0);
    full_frame(0, 2, 0, 1'b0);
    full_frame(2, 2, 0, 1'b0);

    // Random windows, random Valid_IN gaps and coefficient writes racing beats.
    for (int f = 0; f < 3; f++) full_frame(int'($urandom_range(0, 2)), 3, 0, 1'b1);
    for (int n = 0; n < 300; n++) begin
      fill_win(3, 0, 0);
      Valid_IN = 1'($urandom_range(0, 1));
      Coef_WE = ($urandom_range(0, 2) == 0);
      Coef_Addr = 6'($urandom_range(0, 63));
      Coef_Data = CW'($urandom_range(0, 255));
      tick();
    end
    drain();

    // Reset in the middle of a frame, then identity must be back for a clean frame.
    set_coefs(1);
    run_beats(30, 0, 3, 0, 1'b0);
    apply_reset();
    full_frame(0, 3, 0, 1'b0);
    full_frame(1, 1, 0, 1'b0);
    check("identity_after_reset", last_seen, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
